// File: rtl/types_pkg.sv
// ---------------------------------------------------------------------------
// types_pkg
// Shared types for the memory pipeline stage:
//   uword    - instruction word carried through the stage
//   size_e   - access size (BYTE / WORD)
//   memc2_t  - memory control bundle {mem2r, memwr, memrd, size, sgn}
//   mstate_t - stage FSM states (IDLE, REQ, WAIT, HOLD)
// ---------------------------------------------------------------------------
package types_pkg;

  typedef logic [31:0] uword;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } size_e;

  typedef struct packed {
    logic  mem2r;  // write-back takes the load result instead of the ALU result
    logic  memwr;
    logic  memrd;
    size_e size;
    logic  sgn;    // sign-extend byte loads
  } memc2_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } mstate_t;

endpackage

// File: rtl/mem_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe_if
// Memory request/response bus between the pipeline stage and the memory.
//   mreq_valid/mreq_ready  request handshake
//   mreq_we, mreq_addr, mreq_wdata, mreq_be  request payload
//   mrsp_valid, mrsp_rdata                   read response (reads only)
// Modports: master = stage side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic                  mreq_valid;
  logic                  mreq_ready;
  logic                  mreq_we;
  logic [ADDR_W-1:0]     mreq_addr;
  logic [DATA_W-1:0]     mreq_wdata;
  logic [DATA_W/8-1:0]   mreq_be;
  logic                  mrsp_valid;
  logic [DATA_W-1:0]     mrsp_rdata;

  modport master (
    output mreq_valid, mreq_we, mreq_addr, mreq_wdata, mreq_be,
    input  mreq_ready, mrsp_valid, mrsp_rdata
  );

  modport slave (
    input  mreq_valid, mreq_we, mreq_addr, mreq_wdata, mreq_be,
    output mreq_ready, mrsp_valid, mrsp_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the memory stage.
//   lane      in   byte lane (low address bits)
//   size      in   BYTE / WORD
//   sgn       in   sign-extend byte loads
//   st_data   in   store data (register value)
//   ld_raw    in   raw read data from memory
//   st_wdata  out  lane-aligned store data (byte replicated to every lane)
//   st_be     out  byte enables (one-hot for BYTE, all ones for WORD)
//   ld_data   out  extended load result
// ---------------------------------------------------------------------------
module mem_lane_align
  import types_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int LANES  = DATA_W / 8,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic [LANE_W-1:0] lane,
  input  size_e             size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] st_wdata,
  output logic [LANES-1:0]  st_be,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]       lane_byte [LANES];
  logic [LANES-1:0] lane_hit;
  logic [7:0]       sel_byte;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_byte[gi] = ld_raw[gi*8 +: 8];
    assign lane_hit[gi]  = (int'(lane) == gi);
  end

  always_comb begin
    sel_byte = lane_byte[lane];
    if (size == WORD) begin
      st_wdata = st_data;
      st_be    = '1;
      ld_data  = ld_raw;
    end else begin
      // Replicating the byte lets the memory pick it up from whichever lane is enabled.
      st_wdata = {LANES{st_data[7:0]}};
      st_be    = lane_hit;
      ld_data  = {{(DATA_W-8){sgn & sel_byte[7]}}, sel_byte};
    end
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe
// Memory stage of a pipeline: accepts one op, optionally performs a memory
// read or write, and presents the write-back result downstream.
//   clk, rst          clock, synchronous active-high reset
//   halt_sys          freeze all state and handshakes
//   in_valid/in_ready upstream handshake; instruction, alu, memc, r1_data, r0_en
//   mbus (master)     memory request/response bus (mreq_*, mrsp_*)
//   out_valid/out_ready downstream handshake; data, r1_data_out, out_memc,
//                     out_r0_en, instruction_out
//   misalign          misaligned WORD access flag (only with the macro below)
// Optional feature: MEM_STAGE_MISALIGN_TRAP_EN -- misaligned WORD accesses are
// not issued; the op goes straight to HOLD with misalign=1, data=alu and
// out_r0_en=0. Without the macro such accesses are issued unchanged.
// The mbus interface must be instantiated with the same DATA_W/ADDR_W.
// ---------------------------------------------------------------------------
module mem_stage_pipe
  import types_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              in_valid,
  output logic              in_ready,
  input  uword              instruction,
  input  logic [RES_W-1:0]  alu,
  input  memc2_t            memc,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r0_en,
  mem_stage_pipe_if.master  mbus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  data,
  output logic [DATA_W-1:0] r1_data_out,
  output memc2_t            out_memc,
  output logic              out_r0_en,
  output uword              instruction_out
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  mstate_t state_reg, state_next;

  uword              instr_reg;
  logic [RES_W-1:0]  alu_reg;
  memc2_t            memc_reg;
  logic [DATA_W-1:0] r1_reg;
  logic              r0_en_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              mis_reg;
  // Handshakes that land while halted are remembered so the transfer is not
  // lost or repeated once the halt lifts.
  logic              req_acc_reg;
  logic              rsp_got_reg;

  logic              accept;
  logic              is_mem_in;
  logic              mis_in;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_wdata;
  logic [LANES-1:0]  st_be;
  logic [DATA_W-1:0] sel;

  assign is_mem_in = memc.memrd | memc.memwr;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign mis_in   = is_mem_in && (memc.size == WORD) && (alu[LANE_W-1:0] != '0);
  assign misalign = mis_reg;
`else
  assign mis_in   = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state / handshake ----------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    if (!halt_sys) begin
      case (state_reg)
        IDLE: begin
          in_ready = 1'b1;
          accept   = in_valid;
        end
        REQ: begin
          if (mbus.mreq_ready || req_acc_reg) begin
            state_next = memc_reg.memwr ? HOLD : WAIT;
          end
        end
        WAIT: begin
          if (mbus.mrsp_valid || rsp_got_reg) begin
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            in_ready   = 1'b1;
            accept     = in_valid;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
      if (accept) begin
        state_next = (mis_in || !is_mem_in) ? HOLD : REQ;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg   <= '0;
      alu_reg     <= '0;
      memc_reg    <= '0;
      r1_reg      <= '0;
      r0_en_reg   <= 1'b0;
      rdata_reg   <= '0;
      mis_reg     <= 1'b0;
      req_acc_reg <= 1'b0;
      rsp_got_reg <= 1'b0;
    end else begin
      if (accept) begin
        instr_reg <= instruction;
        alu_reg   <= alu;
        memc_reg  <= memc;
        r1_reg    <= r1_data;
        r0_en_reg <= r0_en & ~mis_in;
        mis_reg   <= mis_in;
      end
      // The response is taken even while halted; only the first one counts.
      if ((state_reg == WAIT) && mbus.mrsp_valid && !rsp_got_reg) begin
        rdata_reg <= mbus.mrsp_rdata;
      end
      if (halt_sys) begin
        if ((state_reg == REQ) && mbus.mreq_ready) begin
          req_acc_reg <= 1'b1;
        end
        if ((state_reg == WAIT) && mbus.mrsp_valid) begin
          rsp_got_reg <= 1'b1;
        end
      end else begin
        req_acc_reg <= 1'b0;
        rsp_got_reg <= 1'b0;
      end
    end
  end

  // ---------------- lane steering ----------------
  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .lane     (alu_reg[LANE_W-1:0]),
    .size     (memc_reg.size),
    .sgn      (memc_reg.sgn),
    .st_data  (r1_reg),
    .ld_raw   (rdata_reg),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_data  (ld_data)
  );

  // ---------------- outputs ----------------
  // All outputs come from registers held since capture, so they stay stable
  // through REQ back-pressure and HOLD stalls.
  assign mbus.mreq_valid = (state_reg == REQ);
  assign mbus.mreq_we    = memc_reg.memwr;
  assign mbus.mreq_addr  = alu_reg[ADDR_W-1:0];
  assign mbus.mreq_wdata = st_wdata;
  assign mbus.mreq_be    = st_be;

  assign out_valid       = (state_reg == HOLD);
  assign sel             = (memc_reg.mem2r && !mis_reg) ? ld_data : alu_reg[DATA_W-1:0];
  assign r1_data_out     = r1_reg;
  assign out_memc        = memc_reg;
  assign out_r0_en       = r0_en_reg;
  assign instruction_out = instr_reg;

  if (RES_W > DATA_W) begin : g_data_wide
    assign data = {alu_reg[RES_W-1:DATA_W], sel};
  end else begin : g_data_narrow
    assign data = sel;
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_pipe
// Directed, table-driven bench for mem_stage_pipe with hand-written sequences
// for stalls, halt, reset during an outstanding read and (when
// MEM_STAGE_MISALIGN_TRAP_EN is defined) the misalign trap.
// ---------------------------------------------------------------------------
module tb_mem_stage_pipe;
  import types_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int RES_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt_sys;
  logic              in_valid;
  logic              in_ready;
  uword              instruction;
  logic [RES_W-1:0]  alu;
  memc2_t            memc;
  logic [DATA_W-1:0] r1_data;
  logic              r0_en;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  data;
  logic [DATA_W-1:0] r1_data_out;
  memc2_t            out_memc;
  logic              out_r0_en;
  uword              instruction_out;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mbus ();

  always #5 clk = ~clk;

  mem_stage_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RES_W  (RES_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .halt_sys        (halt_sys),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction     (instruction),
    .alu             (alu),
    .memc            (memc),
    .r1_data         (r1_data),
    .r0_en           (r0_en),
    .mbus            (mbus),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .data            (data),
    .r1_data_out     (r1_data_out),
    .out_memc        (out_memc),
    .out_r0_en       (out_r0_en),
    .instruction_out (instruction_out)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    .misalign        (misalign)
`endif
  );

  typedef struct {
    logic [31:0] alu;
    memc2_t      memc;
    logic [15:0] r1;
    logic        r0_en;
    logic [15:0] rdata;
    int          req_dly;
    int          rsp_dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic memc2_t mc(input logic m2r, input logic wr, input logic rd,
                                input size_e sz, input logic sg);
    memc2_t m;
    m.mem2r = m2r;
    m.memwr = wr;
    m.memrd = rd;
    m.size  = sz;
    m.sgn   = sg;
    return m;
  endfunction

  function automatic vec_t mkv(input logic [31:0] a, input memc2_t m, input logic [15:0] r1,
                               input logic r0, input logic [15:0] rd, input int qd, input int sd,
                               input logic [31:0] ed, input logic [1:0] eb, input logic [15:0] ew);
    vec_t v;
    v.alu = a; v.memc = m; v.r1 = r1; v.r0_en = r0; v.rdata = rd;
    v.req_dly = qd; v.rsp_dly = sd;
    v.exp_data = ed; v.exp_be = eb; v.exp_wdata = ew;
    return v;
  endfunction

  task automatic scramble_inputs();
    in_valid    = 1'b0;
    alu         = 32'hDEAD_DEAD;
    r1_data     = 16'h5A5A;
    instruction = 32'hFFFF_FFFF;
    r0_en       = 1'b0;
    memc        = mc(1'b1, 1'b1, 1'b1, WORD, 1'b1);
  endtask

  // Full transaction: present, (request, response), hold, drain.
  task automatic run_vec(input int i, input vec_t v);
    logic is_mem;
    is_mem = v.memc.memrd | v.memc.memwr;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), in_ready, 1);
    in_valid    = 1'b1;
    alu         = v.alu;
    memc        = v.memc;
    r1_data     = v.r1;
    r0_en       = v.r0_en;
    instruction = 32'hC0DE_0000 + i;
    @(negedge clk);
    scramble_inputs();
    if (is_mem) begin
      for (int c = 0; c <= v.req_dly; c++) begin
        chk($sformatf("v%0d c%0d mreq_valid", i, c), mbus.mreq_valid, 1);
        chk($sformatf("v%0d c%0d mreq_addr", i, c), mbus.mreq_addr, v.alu[15:0]);
        chk($sformatf("v%0d c%0d mreq_we", i, c), mbus.mreq_we, v.memc.memwr);
        if (v.memc.memwr) begin
          chk($sformatf("v%0d c%0d mreq_be", i, c), mbus.mreq_be, v.exp_be);
          chk($sformatf("v%0d c%0d mreq_wdata", i, c), mbus.mreq_wdata, v.exp_wdata);
        end
        chk($sformatf("v%0d c%0d out_valid", i, c), out_valid, 0);
        if (c == v.req_dly) mbus.mreq_ready = 1'b1;
        @(negedge clk);
      end
      mbus.mreq_ready = 1'b0;
      if (v.memc.memrd && !v.memc.memwr) begin
        for (int c = 0; c < v.rsp_dly; c++) begin
          chk($sformatf("v%0d w%0d mreq_valid", i, c), mbus.mreq_valid, 0);
          chk($sformatf("v%0d w%0d out_valid", i, c), out_valid, 0);
          @(negedge clk);
        end
        mbus.mrsp_valid = 1'b1;
        mbus.mrsp_rdata = v.rdata;
        @(negedge clk);
        mbus.mrsp_valid = 1'b0;
        mbus.mrsp_rdata = 16'h0BAD;
      end
    end
    chk($sformatf("v%0d out_valid", i), out_valid, 1);
    chk($sformatf("v%0d data", i), data, v.exp_data);
    chk($sformatf("v%0d out_r0_en", i), out_r0_en, v.r0_en);
    chk($sformatf("v%0d instruction_out", i), instruction_out, 32'hC0DE_0000 + i);
    chk($sformatf("v%0d r1_data_out", i), r1_data_out, v.r1);
    chk($sformatf("v%0d out_memc", i), out_memc, v.memc);
    chk($sformatf("v%0d hold mreq_valid", i), mbus.mreq_valid, 0);
    $display("vec %0d: alu=%h memc=%b data=%h", i, v.alu, v.memc, data);
    @(negedge clk);
    chk($sformatf("v%0d drained out_valid", i), out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b [4];

    // alu, memc(mem2r,wr,rd,size,sgn), r1, r0_en, rdata, req_dly, rsp_dly, exp_data, exp_be, exp_wdata
    vecs[0] = mkv(32'hABCD_1234, mc(0,0,0,WORD,0), 16'h1111, 1, 16'h0000, 0, 0, 32'hABCD_1234, 2'b00, 16'h0000);
    vecs[1] = mkv(32'h0000_0010, mc(0,1,0,WORD,0), 16'hBEEF, 0, 16'h0000, 3, 0, 32'h0000_0010, 2'b11, 16'hBEEF);
    vecs[2] = mkv(32'h0000_0011, mc(1,0,1,BYTE,1), 16'h2222, 1, 16'h80FF, 0, 2, 32'h0000_FF80, 2'b00, 16'h0000);
    vecs[3] = mkv(32'h5555_0010, mc(1,0,1,BYTE,0), 16'h3333, 1, 16'h12F4, 1, 0, 32'h5555_00F4, 2'b00, 16'h0000);
    vecs[4] = mkv(32'h0000_0013, mc(0,1,0,BYTE,0), 16'h12A5, 0, 16'h0000, 0, 0, 32'h0000_0013, 2'b10, 16'hA5A5);
    vecs[5] = mkv(32'h1234_0020, mc(1,0,1,WORD,0), 16'h4444, 1, 16'h8001, 0, 1, 32'h1234_8001, 2'b00, 16'h0000);
    vecs[6] = mkv(32'h0001_0000, mc(1,0,1,BYTE,1), 16'h5555, 1, 16'h7F80, 2, 3, 32'h0001_FF80, 2'b00, 16'h0000);
    vecs[7] = mkv(32'h0000_0100, mc(0,1,0,BYTE,1), 16'h0077, 1, 16'h0000, 1, 0, 32'h0000_0100, 2'b01, 16'h7777);

    rst             = 1'b1;
    halt_sys        = 1'b0;
    out_ready       = 1'b1;
    mbus.mreq_ready = 1'b0;
    mbus.mrsp_valid = 1'b0;
    mbus.mrsp_rdata = 16'h0000;
    scramble_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ---- reset state ----
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset mreq_valid", mbus.mreq_valid, 0);
    chk("reset data", data, 0);
    chk("reset instruction_out", instruction_out, 0);
    $display("reset released");

    // ---- table-driven transactions ----
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // ---- downstream stall then back-to-back non-memory ops ----
    b2b[0] = 32'h1111_2222; b2b[1] = 32'h3333_4444;
    b2b[2] = 32'h5555_6666; b2b[3] = 32'h7777_8888;
    @(negedge clk);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    memc        = mc(0,0,0,WORD,0);
    r0_en       = 1'b1;
    r1_data     = 16'h0000;
    instruction = 32'h0000_00A0;
    alu         = b2b[0];
    @(negedge clk);
    alu = b2b[1];
    instruction = 32'h0000_00A1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stall c%0d out_valid", c), out_valid, 1);
      chk($sformatf("stall c%0d data", c), data, b2b[0]);
      chk($sformatf("stall c%0d in_ready", c), in_ready, 0);
      if (c < 3) @(negedge clk);
    end
    $display("stall: held data=%h for 4 cycles", data);
    out_ready = 1'b1;
    #1;
    chk("stall release in_ready", in_ready, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b %0d out_valid", k), out_valid, 1);
      chk($sformatf("b2b %0d data", k), data, b2b[k]);
      $display("b2b op %0d: data=%h", k, data);
      if (k < 3) begin
        alu = b2b[k+1];
        instruction = 32'h0000_00A0 + k + 1;
      end else begin
        scramble_inputs();
      end
    end
    @(negedge clk);
    chk("b2b drained out_valid", out_valid, 0);

    // ---- halt during REQ and WAIT (byte load, lane 1, zero-extend) ----
    @(negedge clk);
    in_valid    = 1'b1;
    alu         = 32'h0000_0013;
    memc        = mc(1,0,1,BYTE,0);
    r0_en       = 1'b1;
    instruction = 32'h0000_00B0;
    @(negedge clk);
    scramble_inputs();
    halt_sys        = 1'b1;
    mbus.mreq_ready = 1'b1;
    #1;
    chk("halt in_ready", in_ready, 0);
    @(negedge clk);
    mbus.mreq_ready = 1'b0;
    chk("halt REQ mreq_valid held", mbus.mreq_valid, 1);
    halt_sys = 1'b0;
    @(negedge clk);
    chk("halt WAIT mreq_valid", mbus.mreq_valid, 0);
    chk("halt WAIT out_valid", out_valid, 0);
    halt_sys        = 1'b1;
    mbus.mrsp_valid = 1'b1;
    mbus.mrsp_rdata = 16'hA155;
    @(negedge clk);
    mbus.mrsp_valid = 1'b0;
    mbus.mrsp_rdata = 16'h0BAD;
    chk("halt frozen out_valid", out_valid, 0);
    halt_sys = 1'b0;
    @(negedge clk);
    chk("halt resume out_valid", out_valid, 1);
    chk("halt resume data", data, 32'h0000_00A1);
    $display("halt sequence: data=%h", data);
    @(negedge clk);
    chk("halt drained out_valid", out_valid, 0);

    // ---- reset while a read is outstanding, stale response afterwards ----
    in_valid    = 1'b1;
    alu         = 32'h0000_0011;
    memc        = mc(1,0,1,BYTE,1);
    r1_data     = 16'h9999;
    r0_en       = 1'b1;
    instruction = 32'h0000_00C0;
    @(negedge clk);
    scramble_inputs();
    mbus.mreq_ready = 1'b1;
    @(negedge clk);
    mbus.mreq_ready = 1'b0;
    chk("rst-seq WAIT mreq_valid", mbus.mreq_valid, 0);
    chk("rst-seq WAIT out_valid", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    mbus.mrsp_valid = 1'b1;
    mbus.mrsp_rdata = 16'hFFFF;
    chk("post-rst in_ready", in_ready, 1);
    chk("post-rst out_valid", out_valid, 0);
    chk("post-rst mreq_valid", mbus.mreq_valid, 0);
    chk("post-rst data", data, 0);
    chk("post-rst out_r0_en", out_r0_en, 0);
    chk("post-rst out_memc", out_memc, 0);
    chk("post-rst r1_data_out", r1_data_out, 0);
    chk("post-rst instruction_out", instruction_out, 0);
    @(negedge clk);
    mbus.mrsp_valid = 1'b0;
    chk("stale rsp out_valid", out_valid, 0);
    chk("stale rsp data", data, 0);
    chk("stale rsp in_ready", in_ready, 1);
    $display("reset-in-WAIT sequence: out_valid=%b data=%h", out_valid, data);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // ---- misaligned WORD load is trapped ----
    @(negedge clk);
    in_valid    = 1'b1;
    alu         = 32'h0000_0003;
    memc        = mc(1,0,1,WORD,0);
    r0_en       = 1'b1;
    instruction = 32'h0000_00D0;
    @(negedge clk);
    scramble_inputs();
    chk("trap mreq_valid", mbus.mreq_valid, 0);
    chk("trap out_valid", out_valid, 1);
    chk("trap misalign", misalign, 1);
    chk("trap out_r0_en", out_r0_en, 0);
    chk("trap data", data, 32'h0000_0003);
    $display("misalign trap: misalign=%b data=%h", misalign, data);
    @(negedge clk);
    chk("trap drained out_valid", out_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
